// File: rtl/chip8_keypad_pkg.sv
// Shared definitions for the CHIP-8 keypad scan-code decoder:
// PS/2 control byte values, decoder state encoding and the scan-code key map.
package chip8_keypad_pkg;

    localparam logic [7:0] SC_BRK     = 8'hF0;  // break prefix
    localparam logic [7:0] SC_EXT     = 8'hE0;  // extended-key prefix
    localparam logic [7:0] SC_PAUSE   = 8'hE1;  // pause-sequence prefix
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;  // self-test passed
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_RESEND  = 8'hFE;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_OVR_LO  = 8'h00;  // keyboard buffer overrun
    localparam logic [7:0] SC_OVR_HI  = 8'hFF;  // keyboard buffer overrun

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kp_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] key;
    } key_hit_t;

    // Set-2 scan code to CHIP-8 hex key; hit=0 for every unmapped code.
    function automatic key_hit_t scan_to_key(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.key = 4'h0;
        case (code)
            8'h16: r.key = 4'h1;
            8'h1E: r.key = 4'h2;
            8'h26: r.key = 4'h3;
            8'h25: r.key = 4'hC;
            8'h15: r.key = 4'h4;
            8'h1D: r.key = 4'h5;
            8'h24: r.key = 4'h6;
            8'h2D: r.key = 4'hD;
            8'h1C: r.key = 4'h7;
            8'h1B: r.key = 4'h8;
            8'h23: r.key = 4'h9;
            8'h2B: r.key = 4'hE;
            8'h1A: r.key = 4'hA;
            8'h22: r.key = 4'h0;
            8'h21: r.key = 4'hB;
            8'h2A: r.key = 4'hF;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/chip8_keypad_fifo.sv
// Small synchronous show-ahead FIFO holding key-press events. The head entry
// is presented whenever the FIFO is non-empty; flush wins over push and pop.
module key_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr;
    logic [AW:0]                 rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; flush simply realigns the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/chip8_keypad.sv
// PS/2 scan-code decoder producing the CHIP-8 16-key matrix and a queue of
// key-press events for the wait-for-key instruction.
module chip8_keypad
    import chip8_keypad_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_ready,
    input  logic [7:0]  ps2_data,
    output logic [15:0] key_matrix,
    output logic        any_key,
    output logic        ev_valid,
    output logic [3:0]  ev_key,
    input  logic        ev_ready,
    input  logic        ev_flush,
    output logic        ev_overflow
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rdy_last;
    logic                   rdy_rise;
    logic                   byte_vld;
    logic [7:0]             byte_q;

    kp_state_e              state, state_nxt;
    logic [15:0]            km_nxt;
    logic                   press;
    key_hit_t               hit;
    logic                   is_clr;
    logic                   is_nop;

    logic                   push_q;
    logic [3:0]             push_key_q;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign rdy_rise = sync_q[SYNC_STAGES-1] && !rdy_last;

    // Synchronise ps2_ready and latch the data byte once per rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            rdy_last <= 1'b0;
            byte_vld <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ps2_ready};
            rdy_last <= sync_q[SYNC_STAGES-1];
            byte_vld <= rdy_rise;
            if (rdy_rise)
                byte_q <= ps2_data;
        end
    end

    assign hit    = scan_to_key(byte_q);
    assign is_clr = (byte_q == SC_BAT_OK) || (byte_q == SC_OVR_LO) || (byte_q == SC_OVR_HI);
    assign is_nop = (byte_q == SC_ACK) || (byte_q == SC_RESEND) || (byte_q == SC_ECHO);

    // Decode one byte: next state, next matrix and whether a new press occurred.
    always_comb begin
        state_nxt = state;
        km_nxt    = key_matrix;
        press     = 1'b0;
        if (byte_vld) begin
            if (is_clr) begin
                state_nxt = ST_IDLE;
                km_nxt    = '0;
            end else if (is_nop) begin
                state_nxt = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (byte_q == SC_BRK)
                            state_nxt = ST_BRK;
                        else if (byte_q == SC_EXT)
                            state_nxt = ST_EXT;
                        else if (hit.hit && !key_matrix[hit.key]) begin
                            // Typematic repeats of a held key fall through here.
                            km_nxt[hit.key] = 1'b1;
                            press           = 1'b1;
                        end
                    end
                    ST_BRK: begin
                        if (byte_q != SC_BRK) begin
                            state_nxt = ST_IDLE;
                            if (hit.hit)
                                km_nxt[hit.key] = 1'b0;
                        end
                    end
                    ST_EXT:     state_nxt = (byte_q == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                    ST_EXT_BRK: state_nxt = ST_IDLE;
                    default:    state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Register decoder state, matrix, any_key and the pending FIFO push.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            key_matrix <= '0;
            any_key    <= 1'b0;
            push_q     <= 1'b0;
            push_key_q <= 4'h0;
        end else begin
            state      <= state_nxt;
            key_matrix <= km_nxt;
            any_key    <= |km_nxt;
            push_q     <= press;
            push_key_q <= hit.key;
        end
    end

    // Sticky drop flag: a push found the queue full with no pop to make room.
    always_ff @(posedge clk) begin
        if (reset || ev_flush)
            ev_overflow <= 1'b0;
        else if (push_q && fifo_full && !ev_ready)
            ev_overflow <= 1'b1;
    end

    key_event_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_key_q),
        .pop       (ev_ready),
        .flush     (ev_flush),
        .head      (ev_key),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ev_valid = !fifo_empty;

endmodule

// File: tb/tb_chip8_keypad.sv
// Bench for chip8_keypad: directed scenarios plus random byte streams checked
// against a behavioural model of held keys and the press-event queue.
module tb_chip8_keypad;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_ready = 1'b0;
    logic [7:0]  ps2_data = 8'h00;
    logic        ev_ready = 1'b0;
    logic        ev_flush = 1'b0;
    logic [15:0] key_matrix;
    logic        any_key;
    logic        ev_valid;
    logic [3:0]  ev_key;
    logic        ev_overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: held keys, pending prefixes, event queue, overflow flag.
    bit [15:0] m_held;
    bit        m_brk;
    bit        m_ext;
    bit        m_ovf;
    int        m_q[$];

    logic [7:0] key_code [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                                  8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};
    logic [7:0] ctl_codes [7] = '{8'hAA, 8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hEE, 8'hE1};

    chip8_keypad #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_ready   (ps2_ready),
        .ps2_data    (ps2_data),
        .key_matrix  (key_matrix),
        .any_key     (any_key),
        .ev_valid    (ev_valid),
        .ev_key      (ev_key),
        .ev_ready    (ev_ready),
        .ev_flush    (ev_flush),
        .ev_overflow (ev_overflow)
    );

    always #5 clk = ~clk;

    function automatic int code_to_key(input logic [7:0] b);
        for (int k = 0; k < 16; k++)
            if (key_code[k] == b) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_held = '0; m_brk = 0; m_ext = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        k = code_to_key(b);
        if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
            m_held = '0; m_brk = 0; m_ext = 0;
        end else if (b == 8'hFA || b == 8'hFE || b == 8'hEE) begin
            m_brk = 0; m_ext = 0;
        end else if (m_ext) begin
            if (b == 8'hF0 && !m_brk) m_brk = 1;
            else begin m_brk = 0; m_ext = 0; end
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (m_brk) begin
            if (k >= 0) m_held[k] = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (k >= 0 && !m_held[k]) begin
            m_held[k] = 1;
            if (m_q.size() == FIFO_DEPTH) m_ovf = 1;
            else m_q.push_back(k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Send one byte through the PS/2 handshake, then compare every output to the model.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ps2_data  = b;
        ps2_ready = 1'b1;
        repeat (5) @(negedge clk);
        ps2_ready = 1'b0;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        model_byte(b);
        checks++;
        if (key_matrix !== m_held) begin
            errors++; $display("FAIL matrix after %h: got %h expected %h", b, key_matrix, m_held);
        end
        checks++;
        if (any_key !== (m_held != 0)) begin
            errors++; $display("FAIL any_key after %h: got %b expected %b", b, any_key, m_held != 0);
        end
        checks++;
        if (ev_valid !== (m_q.size() > 0)) begin
            errors++; $display("FAIL ev_valid after %h: got %b expected %b", b, ev_valid, m_q.size() > 0);
        end
        checks++;
        if (ev_overflow !== m_ovf) begin
            errors++; $display("FAIL ev_overflow after %h: got %b expected %b", b, ev_overflow, m_ovf);
        end
        if (m_q.size() > 0) begin
            checks++;
            if (ev_key !== 4'(m_q[0])) begin
                errors++; $display("FAIL ev_key after %h: got %h expected %h", b, ev_key, m_q[0]);
            end
        end
    endtask

    // One-cycle pop; on an empty queue this also exercises the ignored-pop case.
    task automatic pop_event();
        @(negedge clk);
        checks++;
        if (ev_valid !== (m_q.size() > 0)) begin
            errors++; $display("FAIL pop ev_valid: got %b expected %b", ev_valid, m_q.size() > 0);
        end
        if (m_q.size() > 0) begin
            checks++;
            if (ev_key !== 4'(m_q[0])) begin
                errors++; $display("FAIL pop ev_key: got %h expected %h", ev_key, m_q[0]);
            end
        end
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (key_matrix !== 16'h0000) begin errors++; $display("FAIL reset key_matrix: got %h expected 0000", key_matrix); end
        if (any_key !== 1'b0)        begin errors++; $display("FAIL reset any_key: got %b expected 0", any_key); end
        if (ev_valid !== 1'b0)       begin errors++; $display("FAIL reset ev_valid: got %b expected 0", ev_valid); end
        if (ev_key !== 4'h0)         begin errors++; $display("FAIL reset ev_key: got %h expected 0", ev_key); end
        if (ev_overflow !== 1'b0)    begin errors++; $display("FAIL reset ev_overflow: got %b expected 0", ev_overflow); end
    endtask

    task automatic test_latency();
        do_reset();
        @(negedge clk);
        ps2_data  = 8'h1C;
        ps2_ready = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (e < SYNC_STAGES + 2) begin
                if (key_matrix !== 16'h0000) begin
                    errors++; $display("FAIL latency early edge %0d: got %h expected 0000", e, key_matrix);
                end
            end else if (e == SYNC_STAGES + 2) begin
                if (key_matrix !== 16'h0080 || any_key !== 1'b1 || ev_valid !== 1'b0) begin
                    errors++; $display("FAIL latency decode edge: got km=%h any=%b ev=%b expected 0080 1 0",
                                       key_matrix, any_key, ev_valid);
                end
            end else begin
                if (ev_valid !== 1'b1 || ev_key !== 4'h7) begin
                    errors++; $display("FAIL latency event edge: got ev=%b key=%h expected 1 7", ev_valid, ev_key);
                end
            end
        end
        repeat (2) @(negedge clk);
        ps2_ready = 1'b0;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        model_byte(8'h1C);
    endtask

    task automatic test_typematic();
        do_reset();
        repeat (3) send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if (key_matrix !== 16'h0000) begin errors++; $display("FAIL typematic release: got %h expected 0000", key_matrix); end
        pop_event();
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL typematic event count: got extra event %h", ev_key); end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'h16);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        checks++;
        if (key_matrix !== 16'h0002) begin errors++; $display("FAIL extended unchanged: got %h expected 0002", key_matrix); end
        send_byte(8'hF0); send_byte(8'h16);
        checks++;
        if (key_matrix !== 16'h0000) begin errors++; $display("FAIL extended release: got %h expected 0000", key_matrix); end
    endtask

    task automatic test_fifo_overflow();
        logic [3:0] exp_keys [4] = '{4'h1, 4'h2, 4'h3, 4'hC};
        do_reset();
        send_byte(8'h16); send_byte(8'h1E); send_byte(8'h26); send_byte(8'h25); send_byte(8'h15);
        checks++;
        if (ev_overflow !== 1'b1) begin errors++; $display("FAIL overflow set: got %b expected 1", ev_overflow); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ev_valid !== 1'b1 || ev_key !== exp_keys[i]) begin
                errors++; $display("FAIL overflow order %0d: got %b/%h expected 1/%h", i, ev_valid, ev_key, exp_keys[i]);
            end
            ev_ready = 1'b1;
            @(negedge clk);
            ev_ready = 1'b0;
            void'(m_q.pop_front());
        end
        pop_event();
        send_byte(8'hF0); send_byte(8'h16);
        send_byte(8'h16);
        @(negedge clk);
        ev_flush = 1'b1;
        @(negedge clk);
        ev_flush = 1'b0;
        m_q.delete(); m_ovf = 0;
        checks++;
        if (ev_valid !== 1'b0 || ev_overflow !== 1'b0) begin
            errors++; $display("FAIL flush: got ev_valid=%b ovf=%b expected 0 0", ev_valid, ev_overflow);
        end
        // Flush landing on the same edge as a push discards the push.
        @(negedge clk);
        ps2_data  = 8'h1D;
        ps2_ready = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            if (e == SYNC_STAGES + 2) ev_flush = 1'b1;
            if (e == SYNC_STAGES + 3) ev_flush = 1'b0;
        end
        @(negedge clk);
        ps2_ready = 1'b0;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        model_byte(8'h1D);
        m_q.delete();
        checks++;
        if (ev_valid !== 1'b0 || key_matrix[5] !== 1'b1) begin
            errors++; $display("FAIL flush vs push: got ev_valid=%b km=%h expected 0, bit5 set", ev_valid, key_matrix);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        send_byte(8'h16); send_byte(8'h1E); send_byte(8'h26); send_byte(8'h25);
        @(negedge clk);
        ps2_data  = 8'h15;
        ps2_ready = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            if (e == SYNC_STAGES + 2) ev_ready = 1'b1;
            if (e == SYNC_STAGES + 3) ev_ready = 1'b0;
        end
        @(negedge clk);
        ps2_ready = 1'b0;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        m_held[4] = 1;
        void'(m_q.pop_front());
        m_q.push_back(4);
        checks++;
        if (ev_overflow !== 1'b0) begin errors++; $display("FAIL full push+pop overflow: got %b expected 0", ev_overflow); end
        checks++;
        if (ev_key !== 4'h2) begin errors++; $display("FAIL full push+pop head: got %h expected 2", ev_key); end
        repeat (5) pop_event();
    endtask

    task automatic test_control();
        do_reset();
        send_byte(8'h1D); send_byte(8'h2D);
        checks++;
        if (key_matrix !== 16'h2020) begin errors++; $display("FAIL control held: got %h expected 2020", key_matrix); end
        send_byte(8'hFF);
        checks++;
        if (key_matrix !== 16'h0000 || any_key !== 1'b0) begin
            errors++; $display("FAIL control clear: got km=%h any=%b expected 0000 0", key_matrix, any_key);
        end
        checks++;
        if (ev_valid !== 1'b1 || ev_key !== 4'h5) begin
            errors++; $display("FAIL control keeps queue: got %b/%h expected 1/5", ev_valid, ev_key);
        end
        send_byte(8'hF0); send_byte(8'hAA); send_byte(8'h1C);
        checks++;
        if (key_matrix !== 16'h0080) begin errors++; $display("FAIL control aborts break: got %h expected 0080", key_matrix); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h22);
        checks++;
        if (key_matrix !== 16'h0001) begin errors++; $display("FAIL reset mid-sequence: got %h expected 0001", key_matrix); end
    endtask

    task automatic test_level_held();
        do_reset();
        @(negedge clk);
        ps2_data  = 8'h1C;
        ps2_ready = 1'b1;
        repeat (6) @(negedge clk);
        ps2_data = 8'h16;
        repeat (44) @(negedge clk);
        ps2_ready = 1'b0;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        model_byte(8'h1C);
        checks++;
        if (key_matrix !== 16'h0080) begin errors++; $display("FAIL level held: got %h expected 0080", key_matrix); end
        pop_event();
        checks++;
        if (ev_valid !== 1'b0) begin errors++; $display("FAIL level held extra event: got %h", ev_key); end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] b;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      b = key_code[$urandom_range(0, 15)];
            else if (r < 70) b = 8'hF0;
            else if (r < 80) b = 8'hE0;
            else if (r < 88) b = ctl_codes[$urandom_range(0, 6)];
            else             b = 8'($urandom_range(0, 255));
            send_byte(b);
            r = $urandom_range(0, 99);
            if (r < 25) pop_event();
            else if (r < 28) begin
                @(negedge clk);
                ev_flush = 1'b1;
                @(negedge clk);
                ev_flush = 1'b0;
                m_q.delete(); m_ovf = 0;
                checks++;
                if (ev_valid !== 1'b0 || ev_overflow !== 1'b0) begin
                    errors++; $display("FAIL random flush: got %b/%b expected 0/0", ev_valid, ev_overflow);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_typematic();
        test_extended();
        test_fifo_overflow();
        test_full_push_pop();
        test_control();
        test_reset_mid();
        test_level_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
